// File: rtl/ahb_sub_mc_pkg.sv
// ahb_sub_mc_pkg: shared constants and types for the AHB-Lite accelerator subordinate.
//   - word-index constants of the register map
//   - htrans / hresp encodings
//   - bus FSM state enum
//   - size_ok(): checks hsize against the bus width
package ahb_sub_mc_pkg;

  // Register map, in words of DATA_W/8 bytes
  localparam int unsigned IdxWeight = 0;  // WO, push with weight flag
  localparam int unsigned IdxInput  = 1;  // WO, push without weight flag
  localparam int unsigned IdxOutput = 2;  // RO, read pops the core result
  localparam int unsigned IdxStatus = 3;  // RO, {status, err}
  localparam int unsigned IdxCtrl   = 4;  // RW, {act[2:0], ctrl[7:0]}
  localparam int unsigned IdxBias0  = 5;  // RW, first bias register

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StErr1,
    StErr2
  } state_e;

  // Only full-width transfers are legal
  function automatic logic size_ok(input logic [2:0] hsize, input int unsigned data_w);
    return hsize == 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/ahb_sub_mc_fifo.sv
// sync_fifo: synchronous FIFO with occupancy count, used as the push buffer.
//   clk_i, rst_i      clock, synchronous active-high reset (discards contents)
//   wr_valid_i/data_i enqueue request; ignored when full
//   rd_ready_i        dequeue request; ignored when empty
//   rd_valid_o/data_o head of queue
//   count_o           registered number of entries
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_valid_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic            rd_ready_i,
  output logic            rd_valid_o,
  output logic [Width-1:0] rd_data_o,
  output logic [CntW-1:0] count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             wr_en, rd_en;

  assign wr_en = wr_valid_i && (count_q != CntW'(Depth));
  assign rd_en = rd_ready_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(wr_en) - CntW'(rd_en);
    end
  end

  // Storage needs no reset; validity is tracked by count_q
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_valid_o = count_q != '0;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/ahb_sub_mc.sv
// ahb_sub_mc: AHB-Lite subordinate for the accelerator register and data path.
//   clk, rst                      clock, synchronous active-high reset
//   hsel..hwdata                  AHB-Lite request (address phase + write data)
//   hrdata, hready, hresp         AHB-Lite response
//   push_valid/ready/data/is_weight  weight/input push buffer toward the core
//   output_data/valid, output_pop core result read with one-cycle pop pulse
//   status_reg, err_reg           core status inputs (read-only registers)
//   ctrl_reg, act_mode, bias_bus  configuration outputs
module ahb_sub_mc
  import ahb_sub_mc_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned NUM_BIAS   = 4,
  parameter int unsigned PUSH_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hsel,
  input  logic [ADDR_W-1:0]          haddr,
  input  logic [1:0]                 htrans,
  input  logic [2:0]                 hsize,
  input  logic                       hwrite,
  input  logic [2:0]                 hburst,
  input  logic [DATA_W-1:0]          hwdata,
  output logic [DATA_W-1:0]          hrdata,
  output logic                       hready,
  output logic                       hresp,
  output logic                       push_valid,
  input  logic                       push_ready,
  output logic [DATA_W-1:0]          push_data,
  output logic                       push_is_weight,
  input  logic [DATA_W-1:0]          output_data,
  input  logic                       output_valid,
  output logic                       output_pop,
  input  logic [7:0]                 status_reg,
  input  logic [15:0]                err_reg,
  output logic [7:0]                 ctrl_reg,
  output logic [2:0]                 act_mode,
  output logic [NUM_BIAS*DATA_W-1:0] bias_bus
);

  localparam int unsigned ByteShift = $clog2(DATA_W / 8);
  localparam int unsigned IdxW      = ADDR_W - ByteShift;
  localparam int unsigned CntW      = $clog2(PUSH_DEPTH + 1);

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic              write_q;
  logic [7:0]        ctrl_q;
  logic [2:0]        act_q;
  logic [DATA_W-1:0] bias_q [NUM_BIAS];

  logic [IdxW-1:0]   a_idx;
  logic              a_err, addr_ph, data_done, push_pend;
  logic [CntW-1:0]   fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic              unused_bits;

  assign unused_bits = ^{htrans[0], hburst};

  // Address-phase decode
  assign a_idx = haddr[ADDR_W-1:ByteShift];

  always_comb begin
    a_err = 1'b0;
    if (a_idx >= IdxW'(IdxBias0 + NUM_BIAS)) a_err = 1'b1;
    if (haddr[ByteShift-1:0] != '0 || !size_ok(hsize, DATA_W)) a_err = 1'b1;
    if (hwrite && (a_idx == IdxW'(IdxOutput) || a_idx == IdxW'(IdxStatus))) a_err = 1'b1;
    if (!hwrite && (a_idx == IdxW'(IdxWeight) || a_idx == IdxW'(IdxInput))) a_err = 1'b1;
    if (!hwrite && a_idx == IdxW'(IdxOutput) && !output_valid) a_err = 1'b1;
  end

  // hready/hresp come only from registered state so no bus input reaches them
  assign push_pend = write_q && (idx_q == IdxW'(IdxWeight) || idx_q == IdxW'(IdxInput));

  always_comb begin
    hready = 1'b1;
    if (state_q == StErr1) hready = 1'b0;
    else if (state_q == StData && push_pend && fifo_count == CntW'(PUSH_DEPTH)) hready = 1'b0;
  end

  assign hresp     = (state_q == StErr1 || state_q == StErr2) ? HrespError : HrespOkay;
  assign addr_ph   = hsel && htrans[1] && hready;  // NONSEQ and SEQ decode alike
  assign data_done = state_q == StData && hready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else if (addr_ph) begin
      state_q <= a_err ? StErr1 : StData;
      idx_q   <= a_idx;
      write_q <= hwrite;
    end else if (state_q == StErr1) begin
      state_q <= StErr2;
    end else if (hready) begin
      state_q <= StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      act_q  <= '0;
      for (int i = 0; i < NUM_BIAS; i++) bias_q[i] <= '0;
    end else if (data_done && write_q) begin
      if (idx_q == IdxW'(IdxCtrl)) begin
        ctrl_q <= hwdata[7:0];
        act_q  <= hwdata[10:8];
      end
      for (int i = 0; i < NUM_BIAS; i++) begin
        if (idx_q == IdxW'(IdxBias0 + i)) bias_q[i] <= hwdata;
      end
    end
  end

  always_comb begin
    hrdata = '0;
    if (state_q == StData && !write_q) begin
      if (idx_q == IdxW'(IdxOutput)) hrdata = output_data;
      if (idx_q == IdxW'(IdxStatus)) hrdata[23:0] = {status_reg, err_reg};
      if (idx_q == IdxW'(IdxCtrl))   hrdata[10:0] = {act_q, ctrl_q};
      for (int i = 0; i < NUM_BIAS; i++) begin
        if (idx_q == IdxW'(IdxBias0 + i)) hrdata = bias_q[i];
      end
    end
  end

  assign output_pop = data_done && !write_q && idx_q == IdxW'(IdxOutput);

  assign ctrl_reg = ctrl_q;
  assign act_mode = act_q;

  for (genvar g = 0; g < NUM_BIAS; g++) begin : g_bias
    assign bias_bus[g*DATA_W +: DATA_W] = bias_q[g];
  end

  sync_fifo #(
    .Width(DATA_W + 1),
    .Depth(PUSH_DEPTH)
  ) u_push_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_valid_i(data_done && push_pend),
    .wr_data_i ({hwdata, idx_q == IdxW'(IdxWeight)}),
    .rd_ready_i(push_ready),
    .rd_valid_o(push_valid),
    .rd_data_o (fifo_head),
    .count_o   (fifo_count)
  );

  assign push_data      = fifo_head[DATA_W:1];
  assign push_is_weight = fifo_head[0];

endmodule

// File: tb/tb_ahb_sub_mc.sv
module tb_ahb_sub_mc;
  import ahb_sub_mc_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 10;
  localparam int unsigned NB = 4;
  localparam int unsigned PD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic          hwrite;
  logic [2:0]    hburst;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic          hresp;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_data;
  logic          push_is_weight;
  logic [DW-1:0] output_data;
  logic          output_valid;
  logic          output_pop;
  logic [7:0]    status_reg;
  logic [15:0]   err_reg;
  logic [7:0]    ctrl_reg;
  logic [2:0]    act_mode;
  logic [NB*DW-1:0] bias_bus;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ahb_sub_mc #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .NUM_BIAS  (NB),
    .PUSH_DEPTH(PD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hsel          (hsel),
    .haddr         (haddr),
    .htrans        (htrans),
    .hsize         (hsize),
    .hwrite        (hwrite),
    .hburst        (hburst),
    .hwdata        (hwdata),
    .hrdata        (hrdata),
    .hready        (hready),
    .hresp         (hresp),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .push_data     (push_data),
    .push_is_weight(push_is_weight),
    .output_data   (output_data),
    .output_valid  (output_valid),
    .output_pop    (output_pop),
    .status_reg    (status_reg),
    .err_reg       (err_reg),
    .ctrl_reg      (ctrl_reg),
    .act_mode      (act_mode),
    .bias_bus      (bias_bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = HtransIdle;
    hwrite = 1'b0;
  endtask

  task automatic bus_addr(input logic wr, input logic [AW-1:0] a, input logic [2:0] sz);
    hsel   = 1'b1;
    htrans = HtransNonseq;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  task automatic check_resp(input string tag, input logic exp_rdy, input logic exp_resp);
    check({tag, "_hready"}, 64'(hready), 64'(exp_rdy));
    check({tag, "_hresp"}, 64'(hresp), 64'(exp_resp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = HtransIdle; hsize = 3'd3; hwrite = 1'b0;
    hburst = 3'd0; hwdata = '0; push_ready = 1'b0; output_data = '0; output_valid = 1'b0;
    status_reg = 8'h12; err_reg = 16'h3456;
    step(); step();

    // Reset state
    @(negedge clk);
    check_resp("rst", 1'b1, 1'b0);
    check("rst_hrdata", hrdata, 64'h0);
    check("rst_push_valid", 64'(push_valid), 64'h0);
    check("rst_output_pop", 64'(output_pop), 64'h0);
    check("rst_ctrl", 64'(ctrl_reg), 64'h0);
    check("rst_act", 64'(act_mode), 64'h0);
    check("rst_bias_any", 64'(|bias_bus), 64'h0);
    step();
    rst = 1'b0;
    step();

    // Bias 2 write then back-to-back read
    bus_addr(1'b1, 10'h038, 3'd3);
    step();
    hwdata = 64'hDEAD_BEEF_0000_0001;
    bus_addr(1'b0, 10'h038, 3'd3);
    @(negedge clk);
    check_resp("bias_wr", 1'b1, 1'b0);
    step();
    bus_idle();
    hwdata = '0;
    @(negedge clk);
    check("bias_rd_data", hrdata, 64'hDEAD_BEEF_0000_0001);
    check_resp("bias_rd", 1'b1, 1'b0);
    check("bias_bus_2", bias_bus[2*DW +: DW], 64'hDEAD_BEEF_0000_0001);
    check("bias_bus_1", bias_bus[1*DW +: DW], 64'h0);
    step();

    // BUSY is a zero-wait OKAY with no action
    hsel = 1'b1; htrans = HtransBusy; hwrite = 1'b1; haddr = 10'h020; hsize = 3'd3;
    step();
    bus_idle();
    hwdata = 64'hFF;
    @(negedge clk);
    check_resp("busy", 1'b1, 1'b0);
    step();
    @(negedge clk);
    check("busy_ctrl", 64'(ctrl_reg), 64'h0);
    step();

    // Write to RO index 3, then hsize 2 to index 4 issued during ERR2
    bus_addr(1'b1, 10'h018, 3'd3);
    step();
    bus_idle();
    hwdata = 64'hFF;
    @(negedge clk);
    check_resp("ro_wr_err1", 1'b0, 1'b1);
    step();
    bus_addr(1'b1, 10'h020, 3'd2);
    @(negedge clk);
    check_resp("ro_wr_err2", 1'b1, 1'b1);
    step();
    bus_idle();
    @(negedge clk);
    check_resp("size_err1", 1'b0, 1'b1);
    step();
    @(negedge clk);
    check_resp("size_err2", 1'b1, 1'b1);
    step();
    @(negedge clk);
    check_resp("size_after", 1'b1, 1'b0);
    check("size_ctrl_kept", 64'(ctrl_reg), 64'h0);
    step();

    // Misaligned full-size write
    bus_addr(1'b1, 10'h024, 3'd3);
    step();
    bus_idle();
    @(negedge clk);
    check_resp("misalign_err1", 1'b0, 1'b1);
    step(); step();

    // Unmapped read
    bus_addr(1'b0, 10'h3F8, 3'd3);
    step();
    bus_idle();
    @(negedge clk);
    check_resp("unmap_err1", 1'b0, 1'b1);
    check("unmap_hrdata", hrdata, 64'h0);
    step();
    @(negedge clk);
    check_resp("unmap_err2", 1'b1, 1'b1);
    step();
    @(negedge clk);
    check_resp("unmap_okay", 1'b1, 1'b0);
    check("unmap_bias_kept", bias_bus[2*DW +: DW], 64'hDEAD_BEEF_0000_0001);
    step();

    // Legal ctrl write, ctrl read-back, status read
    bus_addr(1'b1, 10'h020, 3'd3);
    step();
    hwdata = 64'hFFFF_FFFF_FFFF_F5A3;
    bus_addr(1'b0, 10'h020, 3'd3);
    step();
    bus_addr(1'b0, 10'h018, 3'd3);
    @(negedge clk);
    check("ctrl_rd", hrdata, 64'h5A3);
    check("ctrl_reg", 64'(ctrl_reg), 64'hA3);
    check("act_mode", 64'(act_mode), 64'h5);
    step();
    bus_idle();
    @(negedge clk);
    check("status_rd", hrdata, 64'h12_3456);
    step();

    // Output read with and without a valid result
    output_valid = 1'b1;
    output_data  = 64'h55;
    bus_addr(1'b0, 10'h010, 3'd3);
    step();
    bus_idle();
    @(negedge clk);
    check("out_rd_data", hrdata, 64'h55);
    check("out_pop", 64'(output_pop), 64'h1);
    check_resp("out_rd", 1'b1, 1'b0);
    step();
    output_valid = 1'b0;
    bus_addr(1'b0, 10'h010, 3'd3);
    @(negedge clk);
    check("out_pop_single", 64'(output_pop), 64'h0);
    step();
    bus_idle();
    @(negedge clk);
    check_resp("out_novalid_err1", 1'b0, 1'b1);
    check("out_novalid_pop1", 64'(output_pop), 64'h0);
    step();
    @(negedge clk);
    check("out_novalid_pop2", 64'(output_pop), 64'h0);
    step(); step();

    // Push back-pressure: five weight writes into a depth-4 buffer
    push_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_addr(1'b1, 10'h000, 3'd3);
      hwdata = 64'(i);
      @(negedge clk);
      if (i > 0) check("push_fill_hready", 64'(hready), 64'h1);
      step();
    end
    bus_idle();
    hwdata = 64'd5;
    @(negedge clk);
    check_resp("push_stall", 1'b0, 1'b0);
    check("push_stall_valid", 64'(push_valid), 64'h1);
    step();
    @(negedge clk);
    check("push_stall_hold", 64'(hready), 64'h0);
    step();
    push_ready = 1'b1;
    @(negedge clk);
    check("push_drain_still_stalled", 64'(hready), 64'h0);
    check("push_head_1", push_data, 64'd1);
    check("push_weight_1", 64'(push_is_weight), 64'h1);
    step();
    @(negedge clk);
    check("push_release", 64'(hready), 64'h1);
    check("push_head_2", push_data, 64'd2);
    step();
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      check("push_head_k", push_data, 64'(k));
      check("push_weight_k", 64'(push_is_weight), 64'h1);
      step();
    end
    @(negedge clk);
    check("push_empty", 64'(push_valid), 64'h0);
    step();
    push_ready = 1'b0;

    // Reset during ERR1 with three buffered input words
    for (int i = 0; i < 4; i++) begin
      if (i < 3) bus_addr(1'b1, 10'h008, 3'd3);
      else bus_addr(1'b0, 10'h3F8, 3'd3);
      hwdata = 64'(i + 10);
      step();
    end
    bus_idle();
    rst = 1'b1;
    @(negedge clk);
    check_resp("rstmid_err1", 1'b0, 1'b1);
    check("rstmid_valid_before", 64'(push_valid), 64'h1);
    check("rstmid_head_input", 64'(push_is_weight), 64'h0);
    check("rstmid_head_data", push_data, 64'd11);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_resp("rstmid_after", 1'b1, 1'b0);
    check("rstmid_push_valid", 64'(push_valid), 64'h0);
    check("rstmid_bias", bias_bus[2*DW +: DW], 64'h0);
    step();
    @(negedge clk);
    check("rstmid_push_valid_later", 64'(push_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
